// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: round-robin arbiter granting up to CDB_W finished FU results per cycle onto registered CDB lanes
module cdb_broadcaster #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int PRF_W  = 6,
  parameter int ROB_W  = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU-1:0][PRF_W-1:0]    fu_prf_idx,
  input  logic [NUM_FU-1:0][31:0]         fu_data,
  input  logic [NUM_FU-1:0][ROB_W-1:0]    fu_rob_idx,
  output logic [NUM_FU-1:0]               fu_ready,
  output logic [CDB_W-1:0]                cdb_valid,
  output logic [CDB_W-1:0][PRF_W-1:0]     cdb_prf_idx,
  output logic [CDB_W-1:0][31:0]          cdb_data,
  output logic [CDB_W-1:0][ROB_W-1:0]     cdb_rob_idx,
  output logic [$clog2(CDB_W):0]          cdb_count
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(CDB_W) + 1;
  logic [PTR_W-1:0]              r_rr_ptr;
  logic [CDB_W-1:0]              r_valid;
  logic [CDB_W-1:0][PRF_W-1:0]   r_prf;
  logic [CDB_W-1:0][31:0]        r_data;
  logic [CDB_W-1:0][ROB_W-1:0]   r_rob;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_FU-1:0]             w_ready;
  logic [CDB_W-1:0]              w_lane_vld;
  logic [CDB_W-1:0][PTR_W-1:0]   w_lane_sel;
  logic [CNT_W-1:0]              w_cnt;
  logic [PTR_W-1:0]              w_last;
  logic [PTR_W-1:0]              w_idx;
  logic                          w_take;
  // Scan from rr_ptr with wrap; the k-th grant lands on lane k so lanes stay LSB-contiguous.
  always_comb begin
    w_ready    = '0;
    w_lane_vld = '0;
    w_lane_sel = '0;
    w_cnt      = '0;
    w_last     = r_rr_ptr;
    w_idx      = '0;
    w_take     = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_idx  = PTR_W'((int'(r_rr_ptr) + k) % NUM_FU);
      w_take = fu_valid[w_idx] && (w_cnt < CNT_W'(CDB_W)) && !flush && !reset;
      if (w_take) begin
        w_ready[w_idx] = 1'b1;
        for (int l = 0; l < CDB_W; l++) begin
          if (w_cnt == CNT_W'(l)) begin
            w_lane_sel[l] = w_idx;
            w_lane_vld[l] = 1'b1;
          end
        end
        w_cnt  = w_cnt + CNT_W'(1);
        w_last = w_idx;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_rr_ptr <= '0;
      r_valid  <= '0;
      r_prf    <= '0;
      r_data   <= '0;
      r_rob    <= '0;
      r_cnt    <= '0;
    end else begin
      for (int l = 0; l < CDB_W; l++) begin
        r_valid[l] <= w_lane_vld[l];
        r_prf[l]   <= w_lane_vld[l] ? fu_prf_idx[w_lane_sel[l]] : '0;
        r_data[l]  <= w_lane_vld[l] ? fu_data[w_lane_sel[l]]    : '0;
        r_rob[l]   <= w_lane_vld[l] ? fu_rob_idx[w_lane_sel[l]] : '0;
      end
      r_cnt    <= w_cnt;
      r_rr_ptr <= (w_cnt != '0) ? PTR_W'((int'(w_last) + 1) % NUM_FU) : r_rr_ptr;
    end
  end
  assign fu_ready    = w_ready;
  assign cdb_valid   = r_valid;
  assign cdb_prf_idx = r_prf;
  assign cdb_data    = r_data;
  assign cdb_rob_idx = r_rob;
  assign cdb_count   = r_cnt;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster: directed scenarios with hand-computed grants and CDB lane contents
module tb_cdb_broadcaster;
  localparam int NF = 4, CW = 2, PW = 6, RW = 5;
  logic clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic [NF-1:0] fu_valid = '0;
  logic [NF-1:0][PW-1:0] fu_prf_idx;
  logic [NF-1:0][31:0] fu_data;
  logic [NF-1:0][RW-1:0] fu_rob_idx;
  logic [NF-1:0] fu_ready;
  logic [CW-1:0] cdb_valid;
  logic [CW-1:0][PW-1:0] cdb_prf_idx;
  logic [CW-1:0][31:0] cdb_data;
  logic [CW-1:0][RW-1:0] cdb_rob_idx;
  logic [1:0] cdb_count;
  int n_pass = 0, n_total = 0;

  cdb_broadcaster #(.NUM_FU(NF), .CDB_W(CW), .PRF_W(PW), .ROB_W(RW)) dut (
    .clock(clock), .reset(reset), .flush(flush), .fu_valid(fu_valid),
    .fu_prf_idx(fu_prf_idx), .fu_data(fu_data), .fu_rob_idx(fu_rob_idx),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_prf_idx(cdb_prf_idx),
    .cdb_data(cdb_data), .cdb_rob_idx(cdb_rob_idx), .cdb_count(cdb_count));

  always #5 clock = ~clock;

  function automatic logic [PW-1:0] p_of(int i); return PW'(20 + i); endfunction
  function automatic logic [31:0] d_of(int i); return 32'hCAFE_0000 | 32'(i); endfunction
  function automatic logic [RW-1:0] r_of(int i); return RW'(8 + i); endfunction

  task automatic step; @(posedge clock); #1; endtask

  task automatic load_payloads;
    for (int i = 0; i < NF; i++) begin
      fu_prf_idx[i] = p_of(i);
      fu_data[i] = d_of(i);
      fu_rob_idx[i] = r_of(i);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; fu_valid = 4'b1111;
    step; step;
    n_total++; if (fu_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", fu_ready); else n_pass++;
    n_total++; if (cdb_valid !== 2'b00) $display("FAIL reset_valid got %b exp 00", cdb_valid); else n_pass++;
    n_total++; if (cdb_count !== 2'd0) $display("FAIL reset_count got %0d exp 0", cdb_count); else n_pass++;
    n_total++; if (cdb_data !== '0) $display("FAIL reset_data got %h exp 0", cdb_data); else n_pass++;
    reset = 1'b0; #1;
    n_total++; if (fu_ready !== 4'b0011) $display("FAIL first_grant got %b exp 0011", fu_ready); else n_pass++;
    step;
    fu_valid = 4'b0000;
    n_total++; if (cdb_count !== 2'd2) $display("FAIL first_count got %0d exp 2", cdb_count); else n_pass++;
    n_total++; if (cdb_prf_idx[0] !== p_of(0) || cdb_prf_idx[1] !== p_of(1))
      $display("FAIL first_lanes got %h/%h exp %h/%h", cdb_prf_idx[0], cdb_prf_idx[1], p_of(0), p_of(1)); else n_pass++;
    step;
    n_total++; if (cdb_valid !== 2'b00) $display("FAIL first_drop got %b exp 00", cdb_valid); else n_pass++;
  endtask

  task automatic test_single;
    fu_prf_idx[2] = 6'd17; fu_data[2] = 32'hDEADBEEF; fu_rob_idx[2] = 5'd5;
    fu_valid = 4'b0100; #1;
    n_total++; if (fu_ready !== 4'b0100) $display("FAIL single_ready got %b exp 0100", fu_ready); else n_pass++;
    step;
    fu_valid = 4'b0000;
    n_total++; if (cdb_valid !== 2'b01) $display("FAIL single_valid got %b exp 01", cdb_valid); else n_pass++;
    n_total++; if (cdb_prf_idx[0] !== 6'd17 || cdb_data[0] !== 32'hDEADBEEF || cdb_rob_idx[0] !== 5'd5)
      $display("FAIL single_lane0 got %0d/%h/%0d exp 17/deadbeef/5", cdb_prf_idx[0], cdb_data[0], cdb_rob_idx[0]); else n_pass++;
    n_total++; if (cdb_count !== 2'd1) $display("FAIL single_count got %0d exp 1", cdb_count); else n_pass++;
    n_total++; if (cdb_data[1] !== 32'h0) $display("FAIL single_lane1_zero got %h exp 0", cdb_data[1]); else n_pass++;
    step;
    n_total++; if (cdb_valid !== 2'b00 || cdb_count !== 2'd0) $display("FAIL single_after got %b/%0d exp 00/0", cdb_valid, cdb_count); else n_pass++;
    load_payloads();
  endtask

  task automatic test_hold;
    flush = 1'b1; step; flush = 1'b0;
    fu_valid = 4'b1011; #1;
    n_total++; if (fu_ready !== 4'b0011) $display("FAIL hold_ready1 got %b exp 0011", fu_ready); else n_pass++;
    step;
    fu_valid = 4'b1000; #1;
    n_total++; if (cdb_valid !== 2'b11 || cdb_data[0] !== d_of(0) || cdb_data[1] !== d_of(1))
      $display("FAIL hold_lanes1 got %b %h/%h exp 11 %h/%h", cdb_valid, cdb_data[0], cdb_data[1], d_of(0), d_of(1)); else n_pass++;
    n_total++; if (fu_ready !== 4'b1000) $display("FAIL hold_ready2 got %b exp 1000", fu_ready); else n_pass++;
    step;
    fu_valid = 4'b0000;
    n_total++; if (cdb_valid !== 2'b01 || cdb_data[0] !== d_of(3) || cdb_rob_idx[0] !== r_of(3))
      $display("FAIL hold_lane_fu3 got %b %h/%0d exp 01 %h/%0d", cdb_valid, cdb_data[0], cdb_rob_idx[0], d_of(3), r_of(3)); else n_pass++;
  endtask

  task automatic test_all_valid;
    fu_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_total++; if (fu_ready !== ((c % 2) ? 4'b1100 : 4'b0011))
        $display("FAIL all_ready%0d got %b exp %b", c, fu_ready, (c % 2) ? 4'b1100 : 4'b0011); else n_pass++;
      step;
      n_total++; if (cdb_count !== 2'd2 || cdb_prf_idx[0] !== p_of((c % 2) ? 2 : 0) || cdb_prf_idx[1] !== p_of((c % 2) ? 3 : 1))
        $display("FAIL all_lanes%0d got %0d %h/%h", c, cdb_count, cdb_prf_idx[0], cdb_prf_idx[1]); else n_pass++;
    end
    fu_valid = 4'b0000;
    step;
  endtask

  task automatic test_wrap;
    fu_valid = 4'b0100; #1;
    n_total++; if (fu_ready !== 4'b0100) $display("FAIL wrap_setup got %b exp 0100", fu_ready); else n_pass++;
    step;
    fu_valid = 4'b1001; #1;
    n_total++; if (fu_ready !== 4'b1001) $display("FAIL wrap_ready got %b exp 1001", fu_ready); else n_pass++;
    step;
    n_total++; if (cdb_prf_idx[0] !== p_of(3) || cdb_prf_idx[1] !== p_of(0) || cdb_rob_idx[1] !== r_of(0))
      $display("FAIL wrap_lanes got %h/%h/%0d exp %h/%h/%0d", cdb_prf_idx[0], cdb_prf_idx[1], cdb_rob_idx[1], p_of(3), p_of(0), r_of(0)); else n_pass++;
    fu_valid = 4'b1111; #1;
    n_total++; if (fu_ready !== 4'b0110) $display("FAIL wrap_ptr got %b exp 0110", fu_ready); else n_pass++;
    step;
  endtask

  task automatic test_flush;
    flush = 1'b1; fu_valid = 4'b0110; #1;
    n_total++; if (fu_ready !== 4'b0000) $display("FAIL flush_ready got %b exp 0000", fu_ready); else n_pass++;
    n_total++; if (cdb_valid !== 2'b11 || cdb_prf_idx[0] !== p_of(1) || cdb_prf_idx[1] !== p_of(2))
      $display("FAIL flush_inflight got %b %h/%h exp 11 %h/%h", cdb_valid, cdb_prf_idx[0], cdb_prf_idx[1], p_of(1), p_of(2)); else n_pass++;
    fu_valid = 4'b1111; #1;
    n_total++; if (fu_ready !== 4'b0000) $display("FAIL flush_all_ready got %b exp 0000", fu_ready); else n_pass++;
    step;
    flush = 1'b0;
    n_total++; if (cdb_valid !== 2'b00 || cdb_count !== 2'd0) $display("FAIL flush_after got %b/%0d exp 00/0", cdb_valid, cdb_count); else n_pass++;
    #1;
    n_total++; if (fu_ready !== 4'b0011) $display("FAIL flush_ptr got %b exp 0011", fu_ready); else n_pass++;
    step;
    fu_valid = 4'b0000;
    n_total++; if (cdb_count !== 2'd2) $display("FAIL flush_resume got %0d exp 2", cdb_count); else n_pass++;
  endtask

  task automatic test_reset_beats_flush;
    fu_valid = 4'b1111; reset = 1'b1; flush = 1'b1; #1;
    n_total++; if (fu_ready !== 4'b0000) $display("FAIL rf_ready got %b exp 0000", fu_ready); else n_pass++;
    step;
    reset = 1'b0; flush = 1'b0; #1;
    n_total++; if (cdb_valid !== 2'b00 || fu_ready !== 4'b0011) $display("FAIL rf_after got %b/%b exp 00/0011", cdb_valid, fu_ready); else n_pass++;
    fu_valid = 4'b0000;
    step;
  endtask

  initial begin
    load_payloads();
    test_reset();
    test_single();
    test_hold();
    test_all_valid();
    test_wrap();
    test_flush();
    test_reset_beats_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
